// File: rtl/ex_pkg.sv
// Shared constants and types for the LEGv8 execute stage.
package ex_pkg;

  // ALU operation encodings carried in ALUop
  localparam logic [2:0] ALU_PASSB = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_XOR   = 3'b110;

  // Operand forward selects; 2'b11 falls back to the register value
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Architectural condition flags in {N,Z,V,C} order
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

endpackage

// File: rtl/alu64.sv
// WIDTH-bit ALU with an explicit ripple carry chain and N/Z/V/C flags.
module alu64
  import ex_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             n,
  output logic             z,
  output logic             v,
  output logic             c
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             carry_msb;
  logic             is_arith;

  // Subtraction reuses the adder as A + ~B + 1
  always_comb begin
    is_arith = (op == ALU_ADD) || (op == ALU_SUB);
    b_eff    = (op == ALU_SUB) ? ~b : b;
  end

  // Bit-serial carry chain; the carry-in is the +1 of subtraction
  always_comb begin
    logic cy;
    sum = '0;
    cy  = (op == ALU_SUB);
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b_eff[i] ^ cy;
      cy     = (a[i] & b_eff[i]) | (cy & (a[i] ^ b_eff[i]));
    end
    carry_msb = cy;
  end

  // Operation select; unused encodings produce zero
  always_comb begin
    res = '0;
    case (op)
      ALU_PASSB:        res = b;
      ALU_ADD, ALU_SUB: res = sum;
      ALU_AND:          res = a & b;
      ALU_OR:           res = a | b;
      ALU_XOR:          res = a ^ b;
      default:          res = '0;
    endcase
  end

  // Flags; carry and overflow only have meaning for add/sub
  always_comb begin
    n = res[WIDTH-1];
    z = (res == '0);
    c = is_arith & carry_msb;
    v = is_arith & (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/ex_stage_unit.sv
// Execute stage: operand forwarding, ALU, BL result mux and the N/Z/V/C flag register
// with a same-cycle bypass so B.cond in ID sees flags from an ADDS/SUBS in EX.
module ex_stage_unit
  import ex_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic [WIDTH-1:0] ALU_or_DT,
  input  logic [WIDTH-1:0] alu_result_mem,
  input  logic [WIDTH-1:0] alu_result_wb,
  input  logic [WIDTH-1:0] BLT,
  input  logic [2:0]       ALUop,
  input  logic             ALUsrc,
  input  logic             update,
  input  logic             cbz_id,
  input  logic             BLsignal,
  input  logic [1:0]       forwardA,
  input  logic [1:0]       forwardB,
  output logic [WIDTH-1:0] alu_result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  flags_t           alu_flags;
  flags_t           flags_d;
  flags_t           flags_q;

  // Forwarding muxes for both operands, then immediate/address select for B
  always_comb begin
    case (forwardA)
      FWD_MEM: op_a = alu_result_mem;
      FWD_WB:  op_a = alu_result_wb;
      default: op_a = ReadData1;
    endcase
    case (forwardB)
      FWD_MEM: fwd_b = alu_result_mem;
      FWD_WB:  fwd_b = alu_result_wb;
      default: fwd_b = ReadData2;
    endcase
    op_b = ALUsrc ? ALU_or_DT : fwd_b;
  end

  alu64 #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a   (op_a),
    .b   (op_b),
    .op  (ALUop),
    .res (alu_res),
    .n   (alu_flags.n),
    .z   (alu_flags.z),
    .v   (alu_flags.v),
    .c   (alu_flags.c)
  );

  // Next flag state: load on flag-setting ops, otherwise hold
  always_comb begin
    flags_d = update ? alu_flags : flags_q;
  end

  // Flag register, cleared asynchronously so reset beats a coincident update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  // Stage outputs: BL overrides the result, flags bypass when updating, CBZ sees live Z
  always_comb begin
    alu_result = BLsignal ? BLT : alu_res;
    negative   = update ? alu_flags.n : flags_q.n;
    overflow   = update ? alu_flags.v : flags_q.v;
    carry_out  = update ? alu_flags.c : flags_q.c;
    zero       = (update || cbz_id) ? alu_flags.z : flags_q.z;
  end

endmodule

// File: tb/tb_ex_stage_unit.sv
// Testbench for ex_stage_unit: directed vector table, hand sequences for the
// flag-register corner cases, and randomized checks against a reference model.
module tb_ex_stage_unit;

  typedef struct packed {
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
    logic [63:0] mem;
    logic [63:0] wb;
    logic [63:0] blt;
    logic [2:0]  op;
    logic        src;
    logic        upd;
    logic        cbz;
    logic        bl;
    logic [1:0]  fa;
    logic [1:0]  fb;
  } stim_t;

  typedef struct packed {
    stim_t       s;
    logic [63:0] eres;
    logic        en;
    logic        ez;
    logic        ev;
    logic        ec;
  } vec_t;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;

  logic        clk;
  logic        reset;
  logic [63:0] ReadData1, ReadData2, ALU_or_DT, alu_result_mem, alu_result_wb, BLT;
  logic [2:0]  ALUop;
  logic        ALUsrc, update, cbz_id, BLsignal;
  logic [1:0]  forwardA, forwardB;
  logic [63:0] alu_result;
  logic        negative, zero, overflow, carry_out;

  int total = 0;
  int bad   = 0;

  ex_stage_unit #(.WIDTH(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .ReadData1      (ReadData1),
    .ReadData2      (ReadData2),
    .ALU_or_DT      (ALU_or_DT),
    .alu_result_mem (alu_result_mem),
    .alu_result_wb  (alu_result_wb),
    .BLT            (BLT),
    .ALUop          (ALUop),
    .ALUsrc         (ALUsrc),
    .update         (update),
    .cbz_id         (cbz_id),
    .BLsignal       (BLsignal),
    .forwardA       (forwardA),
    .forwardB       (forwardB),
    .alu_result     (alu_result),
    .negative       (negative),
    .zero           (zero),
    .overflow       (overflow),
    .carry_out      (carry_out)
  );

  // free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkVec(input logic [63:0] rd1, rd2, imm, mem, wb,
                                 input logic [2:0] op, input logic src,
                                 input logic [1:0] fa, fb, input logic bl,
                                 input logic [63:0] blt, eres,
                                 input logic en, ez, ev, ec);
    vec_t v;
    v = '0;
    v.s.rd1 = rd1; v.s.rd2 = rd2; v.s.imm = imm; v.s.mem = mem; v.s.wb = wb;
    v.s.op = op; v.s.src = src; v.s.fa = fa; v.s.fb = fb; v.s.bl = bl;
    v.s.blt = blt; v.s.upd = 1'b1; v.s.cbz = 1'b0;
    v.eres = eres; v.en = en; v.ez = ez; v.ev = ev; v.ec = ec;
    return v;
  endfunction

  // reference model: mathematical add/sub on wider integers
  function automatic logic [63:0] pick(input logic [1:0] sel, input logic [63:0] r,
                                       input logic [63:0] m, input logic [63:0] w);
    if (sel == 2'b10) return m;
    if (sel == 2'b01) return w;
    return r;
  endfunction

  function automatic void model(input stim_t s, output logic [63:0] res,
                                output logic n, z, v, c);
    logic [63:0] a, b;
    logic signed [65:0] exact;
    logic [64:0] usum;
    a = pick(s.fa, s.rd1, s.mem, s.wb);
    b = s.src ? s.imm : pick(s.fb, s.rd2, s.mem, s.wb);
    v = 1'b0;
    c = 1'b0;
    case (s.op)
      3'b000: res = b;
      3'b010: begin
        exact = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
        res   = exact[63:0];
        v     = (exact != $signed({{2{exact[63]}}, exact[63:0]}));
        usum  = {1'b0, a} + {1'b0, b};
        c     = usum[64];
      end
      3'b011: begin
        exact = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
        res   = exact[63:0];
        v     = (exact != $signed({{2{exact[63]}}, exact[63:0]}));
        c     = (a >= b);
      end
      3'b100: res = a & b;
      3'b101: res = a | b;
      3'b110: res = a ^ b;
      default: res = 64'd0;
    endcase
    n = res[63];
    z = (res == 64'd0);
  endfunction

  task automatic applyStimulus(input stim_t s);
    ReadData1 = s.rd1; ReadData2 = s.rd2; ALU_or_DT = s.imm;
    alu_result_mem = s.mem; alu_result_wb = s.wb; BLT = s.blt;
    ALUop = s.op; ALUsrc = s.src; update = s.upd; cbz_id = s.cbz;
    BLsignal = s.bl; forwardA = s.fa; forwardB = s.fb;
    #2;
  endtask

  task automatic checkVal(input string name, input string field,
                          input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s.%s got=%h want=%h", name, field, got, want);
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] eres,
                             input logic en, ez, ev, ec);
    checkVal(name, "alu_result", alu_result, eres);
    checkVal(name, "N", {63'd0, negative},  {63'd0, en});
    checkVal(name, "Z", {63'd0, zero},      {63'd0, ez});
    checkVal(name, "V", {63'd0, overflow},  {63'd0, ev});
    checkVal(name, "C", {63'd0, carry_out}, {63'd0, ec});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t  vecs[16];
  stim_t s;

  initial begin
    logic [63:0] mres;
    logic mn, mz, mv, mc;
    logic [3:0] stored;

    vecs[0]  = mkVec(64'd5, 64'd7, 0, 0, 0, 3'b011, 0, 2'b00, 2'b00, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 0);
    vecs[1]  = mkVec(SMAX, 64'd1, 0, 0, 0, 3'b010, 0, 2'b00, 2'b00, 0, 0, SMIN, 1, 0, 1, 0);
    vecs[2]  = mkVec(64'd1, 0, 64'd3, 64'd10, 64'd20, 3'b010, 1, 2'b10, 2'b00, 0, 0, 64'd13, 0, 0, 0, 0);
    vecs[3]  = mkVec(64'd1, 0, 64'd3, 64'd10, 64'd20, 3'b010, 1, 2'b01, 2'b00, 0, 0, 64'd23, 0, 0, 0, 0);
    vecs[4]  = mkVec(64'd1, 0, 64'd3, 64'd10, 64'd20, 3'b010, 1, 2'b11, 2'b00, 0, 0, 64'd4, 0, 0, 0, 0);
    vecs[5]  = mkVec(64'd9, 64'd9, 0, 0, 0, 3'b011, 0, 2'b00, 2'b00, 0, 0, 64'd0, 0, 1, 0, 1);
    vecs[6]  = mkVec(ALL1, 64'd1, 0, 0, 0, 3'b010, 0, 2'b00, 2'b00, 0, 0, 64'd0, 0, 1, 0, 1);
    vecs[7]  = mkVec(64'hF0F0, 64'hFF00, 0, 0, 0, 3'b100, 0, 2'b00, 2'b00, 0, 0, 64'hF000, 0, 0, 0, 0);
    vecs[8]  = mkVec(64'hF0, 64'h0F, 0, 0, 0, 3'b101, 0, 2'b00, 2'b00, 0, 0, 64'hFF, 0, 0, 0, 0);
    vecs[9]  = mkVec(ALL1, 64'd1, 0, 0, 0, 3'b110, 0, 2'b00, 2'b00, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 0);
    vecs[10] = mkVec(64'd3, 64'd4, 0, 0, 0, 3'b001, 0, 2'b00, 2'b00, 0, 0, 64'd0, 0, 1, 0, 0);
    vecs[11] = mkVec(64'd3, 64'd4, 0, 0, 0, 3'b111, 0, 2'b00, 2'b00, 0, 0, 64'd0, 0, 1, 0, 0);
    vecs[12] = mkVec(0, 64'd7, 0, 64'h55, 0, 3'b000, 0, 2'b00, 2'b10, 0, 0, 64'h55, 0, 0, 0, 0);
    vecs[13] = mkVec(0, 0, 0, 0, 0, 3'b010, 0, 2'b00, 2'b00, 1, 64'h104, 64'h104, 0, 1, 0, 0);
    vecs[14] = mkVec(0, SMIN, 0, 0, 0, 3'b011, 0, 2'b00, 2'b00, 0, 0, SMIN, 1, 0, 1, 0);
    vecs[15] = mkVec(64'd20, 64'd99, 0, 0, 64'd20, 3'b011, 0, 2'b00, 2'b01, 0, 0, 64'd0, 0, 1, 0, 1);

    // reset state: flag register cleared, update low shows stored flags
    s = '0;
    s.op = 3'b011; s.rd1 = 64'd5; s.rd2 = 64'd7;
    reset = 1'b0;
    applyStimulus(s);
    checkOutput("reset_state", 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    tick();

    // directed vector table, each with update=1
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s);
      checkOutput($sformatf("vec%0d", i), vecs[i].eres, vecs[i].en, vecs[i].ez, vecs[i].ev, vecs[i].ec);
      tick();
    end

    // SUBS then hold with an unrelated op
    s = '0; s.rd1 = 64'd5; s.rd2 = 64'd7; s.op = 3'b011; s.upd = 1'b1;
    applyStimulus(s);
    tick();
    s = '0; s.op = 3'b100;
    applyStimulus(s);
    checkOutput("subs_hold", 64'd0, 1, 0, 0, 0);

    // CBZ shows live Z without touching the stored flags
    s = '0; s.op = 3'b000; s.cbz = 1'b1; s.rd1 = 64'd3;
    applyStimulus(s);
    checkOutput("cbz_live", 64'd0, 1, 1, 0, 0);
    tick();
    s.cbz = 1'b0;
    applyStimulus(s);
    checkOutput("cbz_after", 64'd0, 1, 0, 0, 0);

    // ADDS overflow latched, then asynchronous reset between edges
    s = '0; s.rd1 = SMAX; s.rd2 = 64'd1; s.op = 3'b010; s.upd = 1'b1;
    applyStimulus(s);
    tick();
    s.upd = 1'b0;
    applyStimulus(s);
    checkOutput("adds_stored", SMIN, 1, 0, 1, 0);
    #1 reset = 1'b0;
    #2;
    checkOutput("async_reset", SMIN, 0, 0, 0, 0);
    s.rd1 = 64'h10;
    applyStimulus(s);
    checkOutput("reset_result_tracks", 64'h11, 0, 0, 0, 0);
    tick();
    s.upd = 1'b1; s.rd1 = SMAX;
    applyStimulus(s);
    tick();
    s.upd = 1'b0;
    applyStimulus(s);
    checkOutput("reset_beats_update", SMIN, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    checkOutput("reset_release", SMIN, 0, 0, 0, 0);
    tick();

    // randomized run against the reference model
    stored = 4'b0000;
    for (int it = 0; it < 400; it++) begin
      logic [63:0] pool[6];
      s = '0;
      for (int k = 0; k < 6; k++) begin
        case ($urandom_range(0, 4))
          0: pool[k] = 64'($urandom_range(0, 3));
          1: pool[k] = SMAX;
          2: pool[k] = SMIN;
          3: pool[k] = ALL1;
          default: pool[k] = {$urandom, $urandom};
        endcase
      end
      s.rd1 = pool[0]; s.rd2 = pool[1]; s.imm = pool[2];
      s.mem = pool[3]; s.wb = pool[4]; s.blt = pool[5];
      if ($urandom_range(0, 5) == 0) s.rd2 = s.rd1;
      s.op  = 3'($urandom_range(0, 7));
      s.src = 1'($urandom_range(0, 1));
      s.upd = 1'($urandom_range(0, 1));
      s.cbz = ($urandom_range(0, 3) == 0);
      s.bl  = ($urandom_range(0, 5) == 0);
      s.fa  = 2'($urandom_range(0, 3));
      s.fb  = 2'($urandom_range(0, 3));
      model(s, mres, mn, mz, mv, mc);
      applyStimulus(s);
      checkOutput($sformatf("rand%0d", it), s.bl ? s.blt : mres,
                  s.upd ? mn : stored[3],
                  (s.upd || s.cbz) ? mz : stored[2],
                  s.upd ? mv : stored[1],
                  s.upd ? mc : stored[0]);
      tick();
      if (s.upd) stored = {mn, mz, mv, mc};
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
